verificador_dias: RTL



---
 rtl/verificador_pkg.sv | 22 ++
 rtl/temporizador_dia.sv | 35 +++
 rtl/verificador_dias.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/verificador_pkg.sv
// Shared types and constants for the day-decoder tester: FSM states and the day-code table.
package verificador_pkg;

  localparam int unsigned NUM_DIAS_MAX = 8;
  localparam int unsigned DAY_W        = 3;
  localparam int unsigned CODE_W       = 4;
  localparam int unsigned ZYX_W        = 3;
  localparam int unsigned CNT_W        = 4;
  localparam int unsigned PASS_W       = 4;

  typedef enum logic {
    IDLE,
    DRIVE
  } state_t;

  // Day codes as {A,B,C,D}; unused trailing days drive all-zero.
  localparam logic [CODE_W-1:0] DIA_CODE [0:NUM_DIAS_MAX-1] = '{
    4'b0010, 4'b1011, 4'b1111, 4'b1010,
    4'b1100, 4'b0000, 4'b0000, 4'b0000
  };

endpackage

// File: rtl/temporizador_dia.sv
// Per-day settle counter: load clears, enable advances, terminal count when cnt equals SETTLE.
module temporizador_dia
  import verificador_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic tc_c_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c_o = (cnt_q == CNT_W'(SETTLE));

endmodule

// File: rtl/verificador_dias.sv
// Self-checking tester for the day decoder: drives each day code, waits SETTLE cycles,
// samples {Z,Y,X}, compares against EXP and accumulates pass count / fail mask.
module verificador_dias
  import verificador_pkg::*;
#(
  parameter int unsigned               NUM_DIAS = 5,
  parameter int unsigned               SETTLE   = 2,
  parameter logic [3*NUM_DIAS-1:0]     EXP      = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                A,
  output logic                B,
  output logic                C,
  output logic                D,
  input  logic                X,
  input  logic                Y,
  input  logic                Z,
  output logic                busy,
  output logic                done,
  output logic                resp_valid,
  output logic [DAY_W-1:0]    resp_dia,
  output logic [ZYX_W-1:0]    resp_zyx,
  output logic                resp_ok,
  output logic [PASS_W-1:0]   pass_count,
  output logic [NUM_DIAS-1:0] fail_mask
);

  state_t              state_q, state_d;
  logic [DAY_W-1:0]    day_q, day_d;
  logic [CODE_W-1:0]   abcd_q, abcd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DAY_W-1:0]    resp_dia_q, resp_dia_d;
  logic [ZYX_W-1:0]    resp_zyx_q, resp_zyx_d;
  logic                resp_ok_q, resp_ok_d;
  logic [PASS_W-1:0]   pass_count_q, pass_count_d;
  logic [NUM_DIAS-1:0] fail_mask_q, fail_mask_d;

  logic                tmr_load, tmr_en, tmr_tc;
  logic [ZYX_W-1:0]    zyx_in, exp_zyx;
  logic                match;

  temporizador_dia #(
    .SETTLE (SETTLE)
  ) u_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (tmr_load),
    .en_i   (tmr_en),
    .tc_c_o (tmr_tc)
  );

  assign zyx_in = {Z, Y, X};

  // Expected response for the current day, selected with constant slices.
  always_comb begin
    exp_zyx = '0;
    for (int unsigned k = 0; k < NUM_DIAS; k++) begin
      if (day_q == DAY_W'(k)) begin
        exp_zyx = EXP[3*k +: 3];
      end
    end
  end

  assign match = (zyx_in == exp_zyx);

  always_comb begin
    state_d      = state_q;
    day_d        = day_q;
    abcd_d       = abcd_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    resp_valid_d = 1'b0;
    resp_dia_d   = resp_dia_q;
    resp_zyx_d   = resp_zyx_q;
    resp_ok_d    = resp_ok_q;
    pass_count_d = pass_count_q;
    fail_mask_d  = fail_mask_q;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = DRIVE;
          day_d        = '0;
          abcd_d       = DIA_CODE[0];
          busy_d       = 1'b1;
          pass_count_d = '0;
          fail_mask_d  = '0;
          tmr_load     = 1'b1;
        end
      end
      DRIVE: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          resp_valid_d = 1'b1;
          resp_dia_d   = day_q;
          resp_zyx_d   = zyx_in;
          resp_ok_d    = match;
          tmr_load     = 1'b1;
          if (match) begin
            pass_count_d = pass_count_q + PASS_W'(1);
          end else begin
            fail_mask_d = fail_mask_q | (NUM_DIAS'(1) << day_q);
          end
          // Next code goes out in the same cycle the previous response is reported.
          if (day_q < DAY_W'(NUM_DIAS - 1)) begin
            day_d  = day_q + DAY_W'(1);
            abcd_d = DIA_CODE[day_q + DAY_W'(1)];
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            abcd_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      day_q        <= '0;
      abcd_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_dia_q   <= '0;
      resp_zyx_q   <= '0;
      resp_ok_q    <= 1'b0;
      pass_count_q <= '0;
      fail_mask_q  <= '0;
    end else begin
      state_q      <= state_d;
      day_q        <= day_d;
      abcd_q       <= abcd_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      resp_valid_q <= resp_valid_d;
      resp_dia_q   <= resp_dia_d;
      resp_zyx_q   <= resp_zyx_d;
      resp_ok_q    <= resp_ok_d;
      pass_count_q <= pass_count_d;
      fail_mask_q  <= fail_mask_d;
    end
  end

  assign {A, B, C, D} = abcd_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign resp_valid   = resp_valid_q;
  assign resp_dia     = resp_dia_q;
  assign resp_zyx     = resp_zyx_q;
  assign resp_ok      = resp_ok_q;
  assign pass_count   = pass_count_q;
  assign fail_mask    = fail_mask_q;

endmodule
